// File: rtl/core_pkg.sv
// Shared core constants used by the fetch front end and its queue.
package core_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     INST_W   = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam int unsigned     PC_STEP  = 4;

endpackage : core_pkg

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs between memory and decode.
// Power-of-two depth with free-wrapping pointers; flush empties it in one cycle.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = XLEN,
    parameter int unsigned DATA_W = INST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [PC_W-1:0]        push_pc_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [PC_W-1:0]        head_pc_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;
    logic              full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (do_push) begin
            pc_q[wr_ptr_q]   <= push_pc_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_pc_o    = pc_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;

    // The request credit scheme must keep a push from landing in a full queue.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(do_push && full && !do_pop));

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word requests,
// tags in-order responses with their PC, and discards stale responses after a redirect.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned    XLEN     = core_pkg::XLEN,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] queue_count;
    logic [SUM_W-1:0] credit_used;
    logic [XLEN-1:0]  redirect_aligned;
    logic             req_fire;
    logic             push;
    logic             pop;

    // Queue slots plus in-flight requests may never exceed the queue depth.
    assign credit_used      = SUM_W'(queue_count) + SUM_W'(outstanding_q);
    assign imem_req_valid   = !rst && !redirect_valid && (credit_used < SUM_W'(DEPTH));
    assign imem_req_addr    = fetch_pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign pop              = inst_valid && inst_ready && !redirect_valid;

    // Next-state for PCs and the in-flight / to-be-dropped response counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        push          = 1'b0;

        if (req_fire) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(PC_STEP);
            outstanding_d = outstanding_q + CNT_W'(1);
        end

        if (imem_rsp_valid) begin
            outstanding_d = outstanding_d - CNT_W'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                push     = !redirect_valid;
                rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
            end
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_d     = outstanding_d;
            push       = 1'b0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (XLEN),
        .DATA_W (INST_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (rsp_pc_q),
        .push_data_i  (imem_rsp_data),
        .pop_i        (pop),
        .head_valid_o (inst_valid),
        .head_pc_o    (inst_pc),
        .head_data_o  (inst_data),
        .count_o      (queue_count)
    );

    // Memory must only answer requests it has accepted.
    a_no_spurious_rsp : assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outstanding_q == '0)));

    a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
        drop_q <= outstanding_q);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory model.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic        ir;
        logic        exp_iv;
        logic [31:0] exp_ipc;
        logic        exp_rv;
        logic [31:0] exp_addr;
    } vec_t;

    mreq_t       pend[$];
    vec_t        vt[8];
    int          cyc;
    int          lat;
    int          total;
    int          bad;
    int          pops;
    int          mark;
    logic        sb_on;
    logic [31:0] sb_pc;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: apply inputs, present any due memory response, settle.
    task automatic drive(input logic ir, input logic rv, input logic [31:0] rpc, input logic mr);
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = mr;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
            pend.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    // Record accepted requests and score consumed instructions.
    task automatic observe();
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, mem_fn(imem_req_addr), cyc + lat});
        end
        if (sb_on && inst_valid && inst_ready && !redirect_valid) begin
            check("stream_pc", inst_pc, sb_pc);
            check("stream_data", inst_data, mem_fn(sb_pc));
            sb_pc = sb_pc + 32'd4;
            pops++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step(input logic ir, input logic rv, input logic [31:0] rpc, input logic mr);
        drive(ir, rv, rpc, mr);
        observe();
        advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        // cycle index counts from the first cycle with rst low
        vt[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0008};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_000C};
        vt[4] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0010};
        vt[5] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0018};
        vt[7] = '{1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_001C};

        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        cyc = 0; lat = 1; total = 0; bad = 0; pops = 0; sb_on = 1'b0; sb_pc = '0;

        @(negedge clk);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // reset values while rst is held
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        observe();
        advance();

        // streaming from reset, 1-cycle memory, decode always ready
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].ir, 1'b0, 32'h0, 1'b1);
            check("tbl_inst_valid", 32'(inst_valid), 32'(vt[i].exp_iv));
            if (vt[i].exp_iv) begin
                check("tbl_inst_pc", inst_pc, vt[i].exp_ipc);
                check("tbl_inst_data", inst_data, mem_fn(vt[i].exp_ipc));
            end
            check("tbl_req_valid", 32'(imem_req_valid), 32'(vt[i].exp_rv));
            check("tbl_req_addr", imem_req_addr, vt[i].exp_addr);
            observe();
            advance();
        end
        sb_on = 1'b1;
        sb_pc = 32'h0000_0018;

        // decode stall: queue fills to DEPTH and requests stop
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        observe();
        advance();
        mark = pops;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_buffered", 32'(pops - mark), DEPTH);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // latency 3, redirect with three requests in flight
        lat = 3;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (pend.size() >= 3) break;
            step(1'b1, 1'b0, 32'h0, 1'b1);
        end
        check("redir_inflight3", 32'(pend.size()), 32'd3);
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        observe();
        advance();
        sb_pc = 32'h0000_0100;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_inst_valid", 32'(inst_valid), 32'd0);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h0000_0100);
        observe();
        advance();
        mark = pops;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_progress", 32'(pops - mark >= 5), 32'd1);

        // redirect to unaligned target coincident with response and pop
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'h0000_0203, 1'b1);
        check("redir2_pre_valid", 32'(inst_valid), 32'd1);
        observe();
        advance();
        sb_pc = 32'h0000_0200;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir2_inst_valid", 32'(inst_valid), 32'd0);
        check("redir2_req_addr", imem_req_addr, 32'h0000_0200);
        observe();
        advance();
        mark = pops;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir2_progress", 32'(pops - mark >= 3), 32'd1);

        // PC wrap at the top of the address space
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        observe();
        advance();
        sb_pc = 32'hFFFF_FFF8;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        observe();
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
        observe();
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_addr2", imem_req_addr, 32'h0000_0000);
        observe();
        advance();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // reset mid-stream with requests in flight
        lat = 3;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (pend.size() >= 2) break;
            step(1'b1, 1'b0, 32'h0, 1'b1);
        end
        check("mid_rst_inflight", 32'(pend.size() >= 2), 32'd1);
        sb_on = 1'b0;
        rst = 1'b1;
        pend.delete();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        observe();
        advance();
        rst = 1'b0;
        cyc = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("post_rst_inst_pc", inst_pc, 32'h0);
        check("post_rst_inst_data", inst_data, 32'h0);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, RESET_PC);
        sb_on = 1'b1;
        sb_pc = RESET_PC;
        observe();
        advance();
        mark = pops;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("post_rst_progress", 32'(pops - mark >= 4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
